// File: rtl/tone_pkg.sv
// Shared types and constants for the tone generator: FSM states, note index width
// and the half-period table (10 MHz clock, C4..C5 major scale).
package tone_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int NOTE_W = 4;

    // Index 0 is C4 (rightmost element of the concatenation), index 7 is C5.
    localparam logic [7:0][15:0] TABLE = {
        16'd9556,  16'd10124, 16'd11364, 16'd12755,
        16'd14317, 16'd15168, 16'd17026, 16'd19111
    };

    // Scaled half-period, clamped so a heavily shifted entry never stalls the divider.
    function automatic logic [15:0] half_lookup(input logic [2:0] idx, input int shift);
        logic [15:0] v;
        v = TABLE[idx] >> shift;
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

endpackage

// File: rtl/tone_divider.sv
// Reloadable half-period down-counter driving the square-wave phase; the reload value is
// latched on i_load, the phase toggles one cycle after the count reaches zero while enabled.
module tone_divider #(
    parameter int DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_half,
    output logic             o_phase,
    output logic             o_period_end
);

    logic [DIV_W-1:0] r_reload;
    logic [DIV_W-1:0] r_div;
    logic             r_phase;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_reload <= '0;
            r_div    <= '0;
            r_phase  <= 1'b0;
        end else if (i_load) begin
            r_reload <= i_half - DIV_W'(1);
            r_div    <= i_half - DIV_W'(1);
            r_phase  <= 1'b0;
        end else if (i_clr) begin
            r_div    <= '0;
            r_phase  <= 1'b0;
        end else if (i_en) begin
            if (r_div == '0) begin
                r_div   <= r_reload;
                r_phase <= ~r_phase;
            end else begin
                r_div   <= r_div - DIV_W'(1);
            end
        end
    end

    assign o_phase      = r_phase;
    // A high-to-low toggle closes one full period.
    assign o_period_end = i_en & (r_div == '0) & r_phase;

endmodule

// File: rtl/tone_channel.sv
// Single tone voice: accepts one note when idle (no queueing), plays 2*half*dur cycles then GAP_CYC silent.
// audio_o lags sq_o by one cycle; defining TONE_ABORT_EN adds abort_i to cut a note short.
module tone_channel
    import tone_pkg::*;
#(
    parameter int BW        = 3,
    parameter int DIV_W     = 16,
    parameter int DUR_W     = 8,
    parameter int GAP_CYC   = 4,
    parameter int DIV_SHIFT = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
`ifdef TONE_ABORT_EN
    input  logic              abort_i,
`endif
    input  logic              note_valid_i,
    output logic              note_ready_o,
    input  logic [NOTE_W-1:0] note_i,
    input  logic [DUR_W-1:0]  dur_i,
    input  logic [BW-1:0]     vol_i,
    input  logic [BW-1:0]     counter_val_i,
    output logic              sq_o,
    output logic              audio_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    state_t           r_state;
    state_t           w_next;
    logic             r_ready;
    logic             r_done;
    logic             r_audio;
    logic             r_rest;
    logic [DUR_W-1:0] r_dur;
    logic [BW-1:0]    r_vol;
    logic [GAP_W-1:0] r_gap;

    logic             w_accept;
    logic             w_abort;
    logic             w_to_gap;
    logic             w_gap_end;
    logic             w_phase;
    logic             w_period_end;
    logic             w_sq;
    logic [15:0]      w_half_tab;
    logic [DIV_W-1:0] w_half;

`ifdef TONE_ABORT_EN
    assign w_abort = abort_i & (r_state != IDLE);
`else
    assign w_abort = 1'b0;
`endif

    assign w_accept   = note_valid_i & r_ready;
    assign w_half_tab = half_lookup(note_i[2:0], DIV_SHIFT);
    assign w_half     = DIV_W'(w_half_tab);

    always_comb begin
        w_next    = r_state;
        w_to_gap  = 1'b0;
        w_gap_end = 1'b0;
        case (r_state)
            IDLE: if (w_accept) w_next = PLAY;
            PLAY: begin
                if (w_period_end && r_dur == DUR_W'(1)) begin
                    w_next   = GAP;
                    w_to_gap = 1'b1;
                end
            end
            GAP: begin
                if (r_gap == '0) begin
                    w_next    = IDLE;
                    w_gap_end = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
        if (w_abort) begin
            w_next = IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ready <= 1'b0;
            r_done  <= 1'b0;
            r_audio <= 1'b0;
            r_rest  <= 1'b0;
            r_dur   <= '0;
            r_vol   <= '0;
            r_gap   <= '0;
        end else begin
            r_ready <= (w_next == IDLE);
            r_done  <= w_gap_end | w_abort;
            r_audio <= w_sq & (counter_val_i < r_vol);
            if (w_accept) begin
                r_dur  <= (dur_i == '0) ? DUR_W'(1) : dur_i;
                r_vol  <= vol_i;
                r_rest <= note_i[NOTE_W-1];
            end else if (w_period_end && r_dur != DUR_W'(1)) begin
                r_dur  <= r_dur - DUR_W'(1);
            end
            if (w_to_gap) begin
                r_gap <= GAP_W'(GAP_CYC - 1);
            end else if (r_state == GAP && r_gap != '0) begin
                r_gap <= r_gap - GAP_W'(1);
            end
        end
    end

    tone_divider #(.DIV_W(DIV_W)) u_div (
        .i_clk        (clk_i),
        .i_rst        (rst_i),
        .i_load       (w_accept),
        .i_clr        (w_to_gap | w_abort),
        .i_en         (r_state == PLAY),
        .i_half       (w_half),
        .o_phase      (w_phase),
        .o_period_end (w_period_end)
    );

    // Rests run the divider normally so their timing matches a sounding note.
    assign w_sq         = w_phase & ~r_rest;
    assign sq_o         = w_sq;
    assign audio_o      = r_audio;
    assign busy_o       = (r_state != IDLE);
    assign done_o       = r_done;
    assign note_ready_o = r_ready;

endmodule

// File: tb/tb_tone_channel.sv
// Scoreboard bench for tone_channel: stimulus queues per-note expectations, a monitor
// measures each note from busy rise to done pulse and compares.
module tb_tone_channel;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       note_valid_i;
    logic       note_ready_o;
    logic [3:0] note_i;
    logic [7:0] dur_i;
    logic [2:0] vol_i;
    logic [2:0] counter_val_i;
    logic       sq_o, audio_o, busy_o, done_o;
`ifdef TONE_ABORT_EN
    logic       abort_i;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int base     = 0;

    typedef struct {
        string name;
        int    off;
        int    sqh;
        int    edg;
        int    aud;
    } exp_t;
    exp_t exp_q[$];

    int   act = 0;
    int   m_len, m_sqh, m_edg, m_aud;
    logic m_prev;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign counter_val_i = 3'(cyc - base);

    tone_channel #(
        .BW(3), .DIV_W(16), .DUR_W(8), .GAP_CYC(4), .DIV_SHIFT(10)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
`ifdef TONE_ABORT_EN
        .abort_i       (abort_i),
`endif
        .note_valid_i  (note_valid_i),
        .note_ready_o  (note_ready_o),
        .note_i        (note_i),
        .dur_i         (dur_i),
        .vol_i         (vol_i),
        .counter_val_i (counter_val_i),
        .sq_o          (sq_o),
        .audio_o       (audio_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: one window per note, closed by done_o.
    always @(negedge clk) begin
        if (rst_i) begin
            act = 0;
        end else begin
            if (act == 0 && busy_o) begin
                act = 1; m_len = 0; m_sqh = 0; m_edg = 0; m_aud = 0; m_prev = 1'b0;
            end
            if (act != 0) begin
                m_len++;
                m_sqh += int'(sq_o);
                m_aud += int'(audio_o);
                if (sq_o != m_prev) m_edg++;
                m_prev = sq_o;
                if (done_o) begin
                    exp_t e;
                    act = 0;
                    if (exp_q.size() == 0) begin
                        check("done_unexpected", int'(done_o), 0);
                    end else begin
                        e = exp_q.pop_front();
                        check({e.name, "_done_offset"}, m_len - 1, e.off);
                        check({e.name, "_sq_high"}, m_sqh, e.sqh);
                        check({e.name, "_sq_edges"}, m_edg, e.edg);
                        check({e.name, "_audio_high"}, m_aud, e.aud);
                        check({e.name, "_ready_at_done"}, int'(note_ready_o), 1);
                    end
                end
            end else if (done_o) begin
                check("done_unexpected", int'(done_o), 0);
            end
        end
    end

    task automatic push_exp(input string name, input int off, input int sqh,
                            input int edg, input int aud);
        exp_t e;
        e.name = name; e.off = off; e.sqh = sqh; e.edg = edg; e.aud = aud;
        exp_q.push_back(e);
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        @(negedge clk);
        while (!note_ready_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_ready_wait"}, int'(note_ready_o), 1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || act != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, "_completed"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Issue a note at a negedge; counter_val_i reads 0 in the first PLAY cycle.
    task automatic issue(input logic [3:0] n, input logic [7:0] d, input logic [2:0] v);
        note_i = n; dur_i = d; vol_i = v;
        base = cyc + 1;
        note_valid_i = 1'b1;
        @(posedge clk);
        #1 note_valid_i = 1'b0;
    endtask

    task automatic run_note(input string name, input logic [3:0] n, input logic [7:0] d,
                            input logic [2:0] v, input int off, input int sqh,
                            input int edg, input int aud);
        push_exp(name, off, sqh, edg, aud);
        wait_ready(name);
        issue(n, d, v);
        wait_idle(name);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcount;
        rst_i = 1'b1; note_valid_i = 1'b0; note_i = '0; dur_i = '0; vol_i = '0;
`ifdef TONE_ABORT_EN
        abort_i = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_ready", int'(note_ready_o), 0);
        check("rst_busy",  int'(busy_o), 0);
        check("rst_sq",    int'(sq_o), 0);
        check("rst_audio", int'(audio_o), 0);
        check("rst_done",  int'(done_o), 0);
        @(posedge clk);
        #1 rst_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rel_ready", int'(note_ready_o), 1);
        check("rel_busy",  int'(busy_o), 0);
        check("rel_sq",    int'(sq_o), 0);
        check("rel_audio", int'(audio_o), 0);
        check("rel_done",  int'(done_o), 0);

        // half 11, two periods; counter==7 during the high half at PLAY cycles 15 and 39
        run_note("n5_d2_v7", 4'd5, 8'd2, 3'd7, 48, 22, 4, 20);
        // rests: note 9 uses index 1 (half 16), note 15 uses index 7 (half 9)
        run_note("rest9",  4'd9,  8'd1, 3'd7, 36, 0, 0, 0);
        run_note("rest15", 4'd15, 8'd1, 3'd7, 22, 0, 0, 0);
        run_note("n7_dur0_vol0", 4'd7, 8'd0, 3'd0, 22, 9, 2, 0);

        // Command held during PLAY: first note keeps its timing, second is taken at done.
        push_exp("n0_held", 40, 18, 2, 10);
        push_exp("n7_after_held", 22, 9, 2, 0);
        wait_ready("held_first");
        issue(4'd0, 8'd1, 3'd4);
        note_i = 4'd7; dur_i = 8'd1; vol_i = 3'd0;
        note_valid_i = 1'b1;
        wait_ready("held_second");
        @(posedge clk);
        #1 note_valid_i = 1'b0;
        @(negedge clk);
        check("held_accept_busy",  int'(busy_o), 1);
        check("held_accept_ready", int'(note_ready_o), 0);
        wait_idle("held");

        // Asynchronous reset during the high half of a note.
        wait_ready("midrst");
        issue(4'd5, 8'd2, 3'd7);
        repeat (15) @(negedge clk);
        check("midrst_sq_before", int'(sq_o), 1);
        #2 rst_i = 1'b1;
        #1;
        check("midrst_sq",    int'(sq_o), 0);
        check("midrst_audio", int'(audio_o), 0);
        check("midrst_busy",  int'(busy_o), 0);
        check("midrst_ready", int'(note_ready_o), 0);
        check("midrst_done",  int'(done_o), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_i = 1'b0;
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            dcount += int'(done_o);
        end
        check("midrst_no_done", dcount, 0);
        check("midrst_ready_back", int'(note_ready_o), 1);

`ifdef TONE_ABORT_EN
        push_exp("abort", 11, 0, 0, 0);
        wait_ready("abort");
        issue(4'd5, 8'd2, 3'd7);
        repeat (10) @(posedge clk);
        #1 abort_i = 1'b1;
        @(posedge clk);
        #1 abort_i = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(busy_o), 0);
        check("abort_sq",   int'(sq_o), 0);
        wait_idle("abort");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
